// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5) with a 2-bit zero tail per frame.
// Frames arrive in parallel over valid/ready and leave as a serial coded stream, one bit per clock.
module conv_encoder_framer #(
    parameter int DATA_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 y,
    output logic                 y_valid,
    output logic                 frame_start,
    output logic                 frame_done
);

    localparam int INFO_W     = DATA_BITS + 2;
    localparam int FRAME_BITS = 2 * INFO_W;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   bitCnt_q;
    logic [INFO_W-1:0]  info_q;
    logic               s1_q;
    logic               s2_q;
    logic               y_q;
    logic               yValid_q;
    logic               frameStart_q;
    logic               frameDone_q;

    logic               accept;
    logic               infoBit;
    logic               codedBit;

    // Even counts emit the G0 output, odd counts the G1 output of the same info bit.
    always_comb begin
        infoBit  = info_q[INFO_W-1];
        codedBit = bitCnt_q[0] ? (infoBit ^ s2_q) : (infoBit ^ s1_q ^ s2_q);
    end

    assign din_ready = !rst && ((state_q == IDLE) || ((state_q == SEND) && (bitCnt_q == LAST)));
    assign accept    = din_valid && din_ready;

    // Outputs are registered one cycle behind bitCnt_q, so an accept in the last
    // SEND cycle reloads the frame while its final coded bit is being registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            info_q       <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            y_q          <= 1'b0;
            yValid_q     <= 1'b0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    y_q          <= 1'b0;
                    yValid_q     <= 1'b0;
                    frameStart_q <= 1'b0;
                    frameDone_q  <= 1'b0;
                end
                SEND: begin
                    y_q          <= codedBit;
                    yValid_q     <= 1'b1;
                    frameStart_q <= (bitCnt_q == '0);
                    frameDone_q  <= (bitCnt_q == LAST);
                    if (bitCnt_q[0]) begin
                        s2_q   <= s1_q;
                        s1_q   <= infoBit;
                        info_q <= {info_q[INFO_W-2:0], 1'b0};
                    end
                    if (bitCnt_q == LAST) begin
                        state_q  <= IDLE;
                        bitCnt_q <= '0;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                info_q   <= {din, 2'b00};
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                bitCnt_q <= '0;
                state_q  <= SEND;
            end
        end
    end

    assign y           = y_q;
    assign y_valid     = yValid_q;
    assign frame_start = frameStart_q;
    assign frame_done  = frameDone_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed self-checking bench for conv_encoder_framer at the default 5-bit frame size.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_conv_encoder_framer;

    logic       clk;
    logic       rst;
    logic [4:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       y;
    logic       y_valid;
    logic       frame_start;
    logic       frame_done;

    int assertCount = 0;
    int failCount   = 0;

    conv_encoder_framer #(.DATA_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .y          (y),
        .y_valid    (y_valid),
        .frame_start(frame_start),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point of comparison: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] data, input logic valid);
        din       = data;
        din_valid = valid;
    endtask

    // Idle output vector: {din_ready, y_valid, y, frame_start, frame_done}.
    task automatic checkIdle(input string tag);
        checkOutput(tag, 16'({din_ready, y_valid, y, frame_start, frame_done}), 16'(5'b10000));
    endtask

    // Independent reference: convolve the tail-padded bits with 111 and 101.
    function automatic logic [13:0] refEncode(input logic [4:0] d);
        logic [6:0]  u;
        logic [13:0] r;
        logic        cur;
        logic        p1;
        logic        p2;
        u  = {d, 2'b00};
        r  = '0;
        p1 = 1'b0;
        p2 = 1'b0;
        for (int t = 0; t < 7; t++) begin
            cur          = u[6-t];
            r[13-2*t]    = cur ^ p1 ^ p2;
            r[12-2*t]    = cur ^ p2;
            p2           = p1;
            p1           = cur;
        end
        return r;
    endfunction

    // Walks one 14-bit frame that was accepted on the preceding edge; optionally
    // raises din_valid with new data after the sample at index raiseAt.
    task automatic expectFrame(input logic [13:0] bits, input string tag,
                               input int raiseAt, input logic [4:0] raiseData);
        for (int i = 0; i < 14; i++) begin
            tick();
            checkOutput($sformatf("%s_bit%0d", tag, i),
                        16'({y_valid, y, frame_start, frame_done}),
                        16'({1'b1, bits[13-i], (i == 0), (i == 13)}));
            if (i < 13)
                checkOutput($sformatf("%s_ready%0d", tag, i), 16'(din_ready), 16'(i == 12));
            if (i == raiseAt)
                applyStimulus(raiseData, 1'b1);
        end
    endtask

    logic [13:0] expA;
    logic [13:0] expB;
    logic [4:0]  dirData [4];

    initial begin
        expA = 14'b11100001011100;
        expB = 14'b11011010100111;
        dirData[0] = 5'b00001;
        dirData[1] = 5'b10000;
        dirData[2] = 5'b01010;
        dirData[3] = 5'b11001;

        rst = 1'b1;
        applyStimulus(5'b11111, 1'b1);
        tick();
        tick();
        checkOutput("reset_outputs", 16'({din_ready, y_valid, y, frame_start, frame_done}), 16'(0));
        applyStimulus(5'b00000, 1'b0);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkIdle($sformatf("idle%0d", i));
        end

        // Single frame; din scrambled after accept must not disturb the frame in flight.
        applyStimulus(5'b10110, 1'b1);
        checkOutput("single_ready", 16'(din_ready), 16'(1));
        tick();
        applyStimulus(5'b01001, 1'b0);
        expectFrame(expA, "single", -1, 5'b0);
        tick();
        checkIdle("single_after");

        // Back-to-back 11111 then 00000 with din_valid held high.
        applyStimulus(5'b11111, 1'b1);
        tick();
        applyStimulus(5'b00000, 1'b1);
        expectFrame(expB, "b2bA", -1, 5'b0);
        applyStimulus(5'b00000, 1'b0);
        expectFrame(14'b0, "b2bB", -1, 5'b0);
        tick();
        checkIdle("b2b_after");

        // din_valid raised while bit_cnt=5; accepted only in the last cycle.
        applyStimulus(5'b10110, 1'b1);
        tick();
        applyStimulus(5'b10110, 1'b0);
        expectFrame(expA, "mid", 4, 5'b11111);
        applyStimulus(5'b00000, 1'b0);
        expectFrame(expB, "midNext", -1, 5'b0);
        tick();
        checkIdle("mid_after");

        // Reset at bit_cnt=7 aborts the frame; the next frame starts from state 00.
        applyStimulus(5'b10110, 1'b1);
        tick();
        applyStimulus(5'b10110, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput($sformatf("abort_bit%0d", i), 16'({y_valid, y}), 16'({1'b1, expA[13-i]}));
        end
        rst = 1'b1;
        #1;
        checkOutput("abort_ready_in_rst", 16'(din_ready), 16'(0));
        tick();
        rst = 1'b0;
        #1;
        checkOutput("abort_cleared", 16'({y_valid, y, frame_start, frame_done}), 16'(0));
        tick();
        checkIdle("abort_idle");
        applyStimulus(5'b11111, 1'b1);
        tick();
        applyStimulus(5'b00000, 1'b0);
        expectFrame(expB, "postAbort", -1, 5'b0);
        tick();
        checkIdle("postAbort_after");

        // Several data patterns streamed back-to-back against the reference encoder.
        applyStimulus(dirData[0], 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3)
                applyStimulus(dirData[k+1], 1'b1);
            else
                applyStimulus(5'b00000, 1'b0);
            expectFrame(refEncode(dirData[k]), $sformatf("stream%0d", k), -1, 5'b0);
        end
        tick();
        checkIdle("stream_after");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
